// File: rtl/ser_to_para.sv
// Serial-to-parallel receiver for a gated 4-wire segment bus {SEGCLK,SEGCLR,SEGDT,SEGEN}.
// The bus is asynchronous to clk; words arrive MSB first, WIDTH bits per frame.
module ser_to_para #(
  parameter int WIDTH        = 64,
  parameter int IDLE_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       sin,
  output logic [WIDTH-1:0] num,
  output logic             valid,
  output logic             busy,
  output logic             frame_err
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int TW = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
  localparam logic [CW:0]   FULL_CNT = (CW + 1)'(WIDTH);
  localparam logic [TW-1:0] TMO_MAX  = TW'(IDLE_TIMEOUT);
  localparam logic [3:0]    SYNC_RST = 4'b0101;
  localparam logic          IDLE     = 1'b0;
  localparam logic          RECV     = 1'b1;

  logic [3:0]       meta_r;
  logic [3:0]       sync_r;
  logic             clk_prev_r;
  logic             state_r;
  logic [CW-1:0]    cnt_r;
  logic [TW-1:0]    tmo_r;
  logic [WIDTH-1:0] shift_r;
  logic [WIDTH-1:0] num_r;
  logic             valid_r;
  logic             ferr_r;

  logic             seg_clk_s;
  logic             seg_clr_s;
  logic             seg_dt_s;
  logic             seg_en_s;
  logic             accept_s;
  logic             done_s;
  logic [CW:0]      next_cnt_s;
  logic [WIDTH:0]   shift_ext_s;
  logic [WIDTH-1:0] shift_next_s;

  // Two-flop synchronizer for all four bus wires plus SEGCLK history for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r     <= SYNC_RST;
      sync_r     <= SYNC_RST;
      clk_prev_r <= 1'b0;
    end else begin
      meta_r     <= sin;
      sync_r     <= meta_r;
      clk_prev_r <= sync_r[3];
    end
  end

  assign seg_clk_s = sync_r[3];
  assign seg_clr_s = sync_r[2];
  assign seg_dt_s  = sync_r[1];
  assign seg_en_s  = sync_r[0];

  // An edge only counts when the bus is enabled and not being cleared.
  assign accept_s     = seg_clk_s & ~clk_prev_r & seg_en_s & seg_clr_s;
  assign shift_next_s = shift_ext_s[WIDTH-1:0];
  assign done_s       = (next_cnt_s == FULL_CNT);

  // Bit count after accepting the current edge, and the shifted-in data word.
  always_comb begin
    next_cnt_s  = {{CW{1'b0}}, 1'b1};
    shift_ext_s = {shift_r, seg_dt_s};
    if (state_r == RECV) begin
      next_cnt_s = {1'b0, cnt_r} + {{CW{1'b0}}, 1'b1};
    end else begin
      next_cnt_s = {{CW{1'b0}}, 1'b1};
    end
  end

  // Frame FSM: clear beats edge, edge beats timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
      tmo_r   <= {TW{1'b0}};
      shift_r <= {WIDTH{1'b0}};
      num_r   <= {WIDTH{1'b0}};
      valid_r <= 1'b0;
      ferr_r  <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      ferr_r  <= 1'b0;
      if (!seg_clr_s) begin
        state_r <= IDLE;
        cnt_r   <= {CW{1'b0}};
        tmo_r   <= {TW{1'b0}};
        shift_r <= {WIDTH{1'b0}};
      end else if (accept_s) begin
        tmo_r   <= {TW{1'b0}};
        shift_r <= shift_next_s;
        if (done_s) begin
          num_r   <= shift_next_s;
          valid_r <= 1'b1;
          state_r <= IDLE;
          cnt_r   <= {CW{1'b0}};
        end else begin
          state_r <= RECV;
          cnt_r   <= next_cnt_s[CW-1:0];
        end
      end else if (state_r == RECV) begin
        if (tmo_r == TMO_MAX) begin
          ferr_r  <= 1'b1;
          state_r <= IDLE;
          cnt_r   <= {CW{1'b0}};
          tmo_r   <= {TW{1'b0}};
          shift_r <= {WIDTH{1'b0}};
        end else begin
          tmo_r <= tmo_r + {{(TW-1){1'b0}}, 1'b1};
        end
      end else begin
        tmo_r <= {TW{1'b0}};
      end
    end
  end

  assign num       = num_r;
  assign valid     = valid_r;
  assign frame_err = ferr_r;
  assign busy      = (state_r == RECV);

endmodule

// File: tb/tb_ser_to_para.sv
// Self-checking bench for ser_to_para: table-driven frames with a scoreboard queue,
// plus hand-written sequences for timeout, clear, mid-frame reset and SEGEN gating.
module tb_ser_to_para;

  logic        clk;
  logic        rst_n;
  logic [3:0]  sin;
  logic [63:0] num;
  logic        valid;
  logic        busy;
  logic        frame_err;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int vcnt      = 0;
  int ecnt      = 0;
  logic [63:0] exp_q[$];
  logic [63:0] prev_num;

  typedef struct {
    logic [63:0] data;
    logic [63:0] exp;
  } vec_t;
  vec_t vecs[4];

  ser_to_para #(.WIDTH(64), .IDLE_TIMEOUT(255)) dut (
    .clk(clk), .rst_n(rst_n), .sin(sin),
    .num(num), .valid(valid), .busy(busy), .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Scoreboard monitor: compare num on every valid, flag any num change without valid.
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid) begin
        vcnt++;
        if (exp_q.size() == 0) check("unexpected_valid", 64'd1, 64'd0);
        else check("num_on_valid", num, exp_q.pop_front());
      end else if (num !== prev_num) begin
        check("num_stable", num, prev_num);
      end
      if (frame_err) ecnt++;
    end
    prev_num = num;
  end

  // One transmitter bit period is four receiver clocks, SEGCLK low then high.
  task automatic send_bit(input logic b);
    sin[3] = 1'b0;
    sin[1] = b;
    repeat (2) @(negedge clk);
    sin[3] = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_bits(input logic [63:0] d, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) send_bit(d[i]);
  endtask

  task automatic idle(input int n);
    sin[3] = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int v0;
    int e0;
    logic [63:0] w;

    vecs[0] = '{64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF};
    vecs[1] = '{64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000};
    vecs[2] = '{64'h0000_0000_0000_0001, 64'h0000_0000_0000_0001};
    vecs[3] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000};

    rst_n = 1'b0;
    sin   = 4'b0101;
    repeat (3) @(negedge clk);
    check("rst_num", num, 64'h0);
    check("rst_valid", {63'd0, valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_ferr", {63'd0, frame_err}, 64'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Back-to-back frames straight from the table.
    v0 = vcnt;
    e0 = ecnt;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(vecs[i].exp);
      send_bits(vecs[i].data, 63, 0);
    end
    idle(10);
    check("table_valid_count", 64'(vcnt - v0), 64'd4);
    check("table_ferr", 64'(ecnt - e0), 64'd0);
    check("table_busy_after", {63'd0, busy}, 64'd0);
    check("table_drained", 64'(exp_q.size()), 64'd0);

    // Timeout: 20 bits then silence.
    v0 = vcnt;
    e0 = ecnt;
    send_bits(64'hFFFF_FFFF_FFFF_FFFF, 19, 0);
    idle(3);
    check("tmo_busy_mid", {63'd0, busy}, 64'd1);
    idle(300);
    check("tmo_ferr_count", 64'(ecnt - e0), 64'd1);
    check("tmo_valid_count", 64'(vcnt - v0), 64'd0);
    check("tmo_num_hold", num, vecs[3].exp);
    check("tmo_busy_after", {63'd0, busy}, 64'd0);

    // SEGCLR mid-frame, then a full clean frame.
    v0 = vcnt;
    e0 = ecnt;
    send_bits(64'h5555_5555_5555_5555, 29, 0);
    idle(2);
    sin[2] = 1'b0;
    repeat (4) @(negedge clk);
    check("clr_busy", {63'd0, busy}, 64'd0);
    sin[2] = 1'b1;
    repeat (3) @(negedge clk);
    exp_q.push_back(64'hFFFF_0000_A5A5_5A5A);
    send_bits(64'hFFFF_0000_A5A5_5A5A, 63, 0);
    idle(10);
    check("clr_valid_count", 64'(vcnt - v0), 64'd1);
    check("clr_ferr", 64'(ecnt - e0), 64'd0);
    check("clr_num", num, 64'hFFFF_0000_A5A5_5A5A);

    // Reset mid-frame discards the partial word.
    e0 = ecnt;
    send_bits(64'hAAAA_AAAA_AAAA_AAAA, 39, 0);
    sin[3] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_num", num, 64'h0);
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_ferr", {63'd0, frame_err}, 64'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    v0 = vcnt;
    exp_q.push_back(64'hDEAD_BEEF_CAFE_F00D);
    send_bits(64'hDEAD_BEEF_CAFE_F00D, 63, 0);
    idle(10);
    check("midrst_valid_count", 64'(vcnt - v0), 64'd1);
    check("midrst_ferr_count", 64'(ecnt - e0), 64'd0);
    check("midrst_num_after", num, 64'hDEAD_BEEF_CAFE_F00D);

    // SEGEN=0 pulses inside a frame must not shift anything.
    w  = 64'h3C3C_1234_5678_9ABC;
    v0 = vcnt;
    send_bits(w, 63, 54);
    idle(2);
    sin[0] = 1'b0;
    for (int i = 0; i < 8; i++) send_bit(i[0]);
    idle(2);
    check("en_busy_held", {63'd0, busy}, 64'd1);
    check("en_valid_none", 64'(vcnt - v0), 64'd0);
    check("en_num_held", num, 64'hDEAD_BEEF_CAFE_F00D);
    sin[0] = 1'b1;
    exp_q.push_back(w);
    send_bits(w, 53, 0);
    idle(10);
    check("en_valid_count", 64'(vcnt - v0), 64'd1);
    check("en_num", num, w);
    check("final_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/ser_to_para.md
SER_TO_PARA -- requirements
Module: ser_to_para

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64: number of data bits per frame.
REQ-002 The block SHALL have parameter IDLE_TIMEOUT, default 255: receiver clocks without a SEGCLK edge before a partial frame is aborted.
REQ-003 The block SHALL have port clk  input  1: receiver clock, at least 4x the transmitter clock frequency.
REQ-004 The block SHALL have port rst_n  input  1: reset, asynchronous, active-low.
REQ-005 The block SHALL have port sin  input  4: serial bus {SEGCLK,SEGCLR,SEGDT,SEGEN}, asynchronous to clk.
REQ-006 The block SHALL have port num  output  WIDTH: last complete received word, MSB received first.
REQ-007 The block SHALL have port valid  output  1: one-cycle pulse when num is updated.
REQ-008 The block SHALL have port busy  output  1: high while a frame is partially received.
REQ-009 The block SHALL have port frame_err  output  1: one-cycle pulse on timeout abort.

Function
REQ-010 The block SHALL pass SEGCLK, SEGCLR, SEGDT and SEGEN each through a 2-flop synchronizer; all logic SHALL use only synchronized values.
REQ-011 The block SHALL detect a SEGCLK rising edge as synchronized SEGCLK=1 with its previous synchronized value=0; call that cycle E.
REQ-012 The block SHALL ignore an edge at E when synchronized SEGEN=0 or synchronized SEGCLR=0; an ignored edge SHALL NOT shift data or restart the timeout.
REQ-013 The block SHALL sample synchronized SEGDT at cycle E and shift it into the LSB of an internal WIDTH-bit shift register, moving earlier bits toward the MSB.
REQ-014 The block SHALL implement states IDLE and RECV, plus a bit counter 0..WIDTH-1 and a timeout counter wide enough to hold IDLE_TIMEOUT.
REQ-015 In IDLE, an accepted edge SHALL shift in the bit, set the bit counter to 1, clear the timeout counter, and move to RECV.
REQ-016 In RECV, an accepted edge SHALL shift in the bit, increment the bit counter, and clear the timeout counter.
REQ-017 In RECV, when the edge capturing bit number WIDTH is accepted at cycle E, the block SHALL, at E+1: load num with the full shift register, pulse valid for exactly one cycle, return to IDLE, and clear the bit counter.
REQ-018 In RECV, the timeout counter SHALL increment on every cycle with no accepted edge.
REQ-019 When the timeout counter reaches IDLE_TIMEOUT, the block SHALL, on the next cycle: pulse frame_err for one cycle, return to IDLE, clear the bit counter and shift register, and leave num unchanged.
REQ-020 Synchronized SEGCLR=0 in any state SHALL, on the next cycle: clear the shift register, bit counter and timeout counter, and force IDLE, with no valid and no frame_err; this SHALL take priority over edge and timeout.
REQ-021 If an edge is accepted in the same cycle the timeout counter reaches IDLE_TIMEOUT, the edge SHALL win and no frame_err SHALL be raised.
REQ-022 busy SHALL equal (state == RECV).
REQ-023 num SHALL change only together with a valid pulse.
REQ-024 An edge accepted in the cycle after valid SHALL start a new frame, so back-to-back frames lose no bits.
REQ-025 An all-zero data word SHALL be received normally; frame completion SHALL depend only on the edge count, never on data content.

Reset
REQ-026 While rst_n=0 the block SHALL force: num=0, valid=0, busy=0, frame_err=0, state IDLE, all counters and the shift register 0.
REQ-027 While rst_n=0 the synchronizer flops SHALL reset to SEGCLK=0, SEGCLR=1, SEGDT=0, SEGEN=1.
REQ-028 After rst_n deasserts, the first accepted SEGCLK rising edge SHALL be treated as bit 1 of a new frame.
REQ-029 Reset asserted mid-frame SHALL discard the partial frame without a frame_err pulse.

Verification
REQ-030 Bench SHALL drive 64'h0123_4567_89AB_CDEF MSB first at a transmitter clock of clk/4 (64 gated SEGCLK pulses, SEGCLR=SEGEN=1) -> num=64'h0123_4567_89AB_CDEF with exactly one valid pulse, and busy low afterwards.
REQ-031 Bench SHALL send an all-zero frame -> valid pulses once and num=64'h0.
REQ-032 Bench SHALL send 20 bits, then hold SEGCLK low for 300 clk -> exactly one frame_err pulse, no valid, num holds its previous value, busy=0.
REQ-033 Bench SHALL pull SEGCLR low after 30 bits, then send a full frame 64'hFFFF_0000_A5A5_5A5A -> no frame_err, and exactly one valid with num=64'hFFFF_0000_A5A5_5A5A.
REQ-034 Bench SHALL assert rst_n=0 after 40 bits, then release it and send 64'hDEAD_BEEF_CAFE_F00D -> num=0 during reset, then num=64'hDEAD_BEEF_CAFE_F00D.
REQ-035 Bench SHALL send two back-to-back frames 64'h1 and 64'h8000_0000_0000_0000 -> two valid pulses with num matching each frame in order.
REQ-036 Bench SHALL pulse SEGCLK with SEGEN=0 -> no shift, num, busy and counters unchanged.
